alu_sequencer_fsm: RTL

//  Moore FSM that sequences the 16-bit register-file/ALU datapath for one instruction at a time.

---
 rtl/alu_sequencer_fsm_if.sv | 33 +++
 rtl/alu_sequencer_fsm.sv | 129 ++++++++++++
 2 files changed

// File: rtl/alu_sequencer_fsm_if.sv
// Control bundle between the instruction register side (master) and the
// datapath sequencer (slave).
interface alu_sequencer_fsm_if #(
  parameter int DATA_W = 16
);
  logic              s;
  logic [15:0]       instr;
  logic              w;
  logic [2:0]        nsel;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic [1:0]        vsel;
  logic              write;
  logic [1:0]        alu_op;
  logic [1:0]        shift;
  logic [DATA_W-1:0] sximm8;
  logic              err;

  modport master (
    output s, instr,
    input  w, nsel, loada, loadb, loadc, loads, asel, vsel, write,
           alu_op, shift, sximm8, err
  );

  modport slave (
    input  s, instr,
    output w, nsel, loada, loadb, loadc, loads, asel, vsel, write,
           alu_op, shift, sximm8, err
  );
endinterface

// File: rtl/alu_sequencer_fsm.sv
// Moore sequencer for one register-file/ALU instruction at a time: latches the
// instruction on the start handshake and steps the datapath controls through it.
module alu_sequencer_fsm #(
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_sequencer_fsm_if.slave ctl
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic       is_movi, is_movr, is_arith, is_cmp;

  assign opcode   = ir_q[15:13];
  assign op       = ir_q[12:11];
  assign is_movi  = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr  = (opcode == 3'b110) && (op == 2'b00);
  assign is_arith = (opcode == 3'b101);
  assign is_cmp   = is_arith && (op == 2'b01);

  assign ctl.sximm8 = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ctl.w      = 1'b0;
    ctl.nsel   = 3'b000;
    ctl.loada  = 1'b0;
    ctl.loadb  = 1'b0;
    ctl.loadc  = 1'b0;
    ctl.loads  = 1'b0;
    ctl.asel   = 1'b0;
    ctl.vsel   = 2'b00;
    ctl.write  = 1'b0;
    ctl.alu_op = 2'b00;
    ctl.shift  = 2'b00;
    ctl.err    = 1'b0;

    case (state_q)
      S_WAIT: begin
        ctl.w = 1'b1;
        if (ctl.s) begin
          ir_d    = ctl.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // MVN ignores the A operand, so it skips GET_A just like MOVR.
        if (is_movi)
          state_d = S_WRITE_IMM;
        else if (is_movr || (is_arith && op == 2'b11))
          state_d = S_GET_B;
        else if (is_arith)
          state_d = S_GET_A;
        else begin
          ctl.err = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WRITE_IMM: begin
        ctl.nsel  = 3'b100;
        ctl.vsel  = 2'b01;
        ctl.write = 1'b1;
        state_d   = S_WAIT;
      end
      S_GET_A: begin
        ctl.nsel  = 3'b100;
        ctl.loada = 1'b1;
        state_d   = S_GET_B;
      end
      S_GET_B: begin
        ctl.nsel  = 3'b001;
        ctl.loadb = 1'b1;
        ctl.shift = ir_q[4:3];
        state_d   = S_ALU;
      end
      S_ALU: begin
        ctl.shift = ir_q[4:3];
        if (is_movr) begin
          // MOVR is computed as 0 + shifted Rm and leaves status untouched.
          ctl.asel  = 1'b1;
          ctl.loadc = 1'b1;
          state_d   = S_WRITE_REG;
        end else begin
          ctl.alu_op = op;
          ctl.loads  = 1'b1;
          if (is_cmp)
            state_d = S_WAIT;
          else begin
            ctl.loadc = 1'b1;
            state_d   = S_WRITE_REG;
          end
        end
      end
      S_WRITE_REG: begin
        ctl.nsel  = 3'b010;
        ctl.write = 1'b1;
        ctl.shift = ir_q[4:3];
        state_d   = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule
